// File: rtl/spart_rx_fifo.sv
// 16x-oversampled serial receiver feeding a first-word fall-through FIFO of {frame_err, parity_err, data}.
// Define SPART_RX_MAJORITY_EN to decide every sample by a 2-of-3 vote around the sample tick.
module spart_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              rxd,
  input  logic              rd,
  output logic [DATA_W-1:0] data,
  output logic              rda,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = DATA_W + 2;
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t              state, state_nx;
  logic                sync1, sync2, prev;
  logic [3:0]          cnt, bits;
  logic [DATA_W-1:0]   shreg;
  logic                perr, ferr;
  logic                smp_en, smp_val, push;

`ifdef SPART_RX_MAJORITY_EN
  // m0/m1 hold the two early votes; pend marks that the deciding tick 0 belongs to the current bit.
  logic m0, m1, pend;

  always_comb begin
    smp_en  = 1'b0;
    smp_val = (m0 & m1) | (m0 & sync2) | (m1 & sync2);
    if (enable) begin
      case (state)
        START:          smp_en = (cnt == 4'd8);
        DATA, PAR, STOP: smp_en = pend && (cnt == 4'd0);
        default:        smp_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      m0   <= 1'b1;
      m1   <= 1'b1;
      pend <= 1'b0;
    end else if (enable) begin
      if (state == IDLE) begin
        pend <= 1'b0;
      end else if (state == START) begin
        if (cnt == 4'd6) m0 <= sync2;
        if (cnt == 4'd7) m1 <= sync2;
      end else begin
        if (cnt == 4'd14) m0 <= sync2;
        if (cnt == 4'd15) begin
          m1   <= sync2;
          pend <= 1'b1;
        end else if (cnt == 4'd0) begin
          pend <= 1'b0;
        end
      end
    end
  end
`else
  always_comb begin
    smp_val = sync2;
    smp_en  = 1'b0;
    if (enable) begin
      case (state)
        START:           smp_en = (cnt == 4'd7);
        DATA, PAR, STOP: smp_en = (cnt == 4'd15);
        default:         smp_en = 1'b0;
      endcase
    end
  end
`endif

  always_comb begin
    state_nx = state;
    push     = 1'b0;
    case (state)
      IDLE:  if (enable && !sync2 && prev) state_nx = START;
      START: if (smp_en) state_nx = smp_val ? IDLE : DATA;
      DATA:  if (smp_en && bits == 4'(DATA_W-1)) state_nx = (PARITY != 0) ? PAR : STOP;
      PAR:   if (smp_en) state_nx = STOP;
      STOP:  if (smp_en && bits == 4'(STOP_BITS-1)) begin
               state_nx = IDLE;
               push     = 1'b1;
             end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
      cnt   <= '0;
      bits  <= '0;
      shreg <= '0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      sync1 <= rxd;
      sync2 <= sync1;
      state <= state_nx;
      if (enable) begin
        prev <= sync2;
        cnt  <= cnt + 4'd1;
        // Counter restarts both at start detection and at the start-bit decision.
        if (state == IDLE || (state == START && smp_en)) begin
          cnt  <= '0;
          bits <= '0;
          perr <= 1'b0;
          ferr <= 1'b0;
        end
      end
      if (smp_en) begin
        case (state)
          DATA: begin
            shreg <= {smp_val, shreg[DATA_W-1:1]};
            bits  <= (bits == 4'(DATA_W-1)) ? 4'd0 : bits + 4'd1;
          end
          PAR:  perr <= smp_val ^ (^shreg) ^ (PARITY == 2);
          STOP: begin
            bits <= bits + 4'd1;
            if (!smp_val) ferr <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          full, do_push, do_pop;
  logic [EW-1:0] head;

  assign full    = (count == CNT_FULL);
  assign rda     = (count != '0);
  // A full FIFO still accepts the frame when the head leaves on the same clk.
  assign do_push = push && (!full || rd);
  assign do_pop  = rd && rda;
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= {ferr | ~smp_val, perr, shreg};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
      if (push && full && !rd)
        overrun <= 1'b1;
      else if (do_pop && !do_push && count == CNT_ONE)
        overrun <= 1'b0;
    end
  end

  assign data       = rda ? head[DATA_W-1:0] : '0;
  assign parity_err = rda & head[DATA_W];
  assign frame_err  = rda & head[DATA_W+1];
endmodule

// File: tb/tb_spart_rx_fifo.sv
// Directed bench: default, even-parity and two-stop-bit receivers driven with hand-built frames.
module tb_spart_rx_fifo;
  logic clk = 1'b0;
  logic rst, enable, rxd_a, rxd_b, rxd_c, rd_a, rd_b, rd_c;
  logic [7:0] data_a, data_b, data_c;
  logic rda_a, rda_b, rda_c, pe_a, pe_b, pe_c, fe_a, fe_b, fe_c, ov_a, ov_b, ov_c;
  int checks = 0;
  int fails  = 0;

`ifdef SPART_RX_MAJORITY_EN
  localparam int SMP = 10;
  localparam int GLT = 9;
`else
  localparam int SMP = 8;
  localparam int GLT = 8;
`endif

  always #5 clk = ~clk;

  spart_rx_fifo u_def (.clk(clk), .rst(rst), .enable(enable), .rxd(rxd_a), .rd(rd_a),
    .data(data_a), .rda(rda_a), .parity_err(pe_a), .frame_err(fe_a), .overrun(ov_a));
  spart_rx_fifo #(.PARITY(1)) u_par (.clk(clk), .rst(rst), .enable(enable), .rxd(rxd_b), .rd(rd_b),
    .data(data_b), .rda(rda_b), .parity_err(pe_b), .frame_err(fe_b), .overrun(ov_b));
  spart_rx_fifo #(.STOP_BITS(2)) u_st2 (.clk(clk), .rst(rst), .enable(enable), .rxd(rxd_c), .rd(rd_c),
    .data(data_c), .rda(rda_c), .parity_err(pe_c), .frame_err(fe_c), .overrun(ov_c));

  // One 16x tick: line settles through the synchronizer before enable pulses.
  task automatic tick(input logic [2:0] v, input logic r);
    @(negedge clk); rxd_a = v[0]; rxd_b = v[1]; rxd_c = v[2];
    @(negedge clk);
    @(negedge clk); enable = 1'b1; rd_a = r;
    @(negedge clk); enable = 1'b0; rd_a = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(3'b111, 1'b0);
  endtask

  task automatic pop(input int line);
    @(negedge clk);
    case (line) 0: rd_a = 1'b1; 1: rd_b = 1'b1; default: rd_c = 1'b1; endcase
    @(negedge clk);
    rd_a = 1'b0; rd_b = 1'b0; rd_c = 1'b0;
  endtask

  task automatic send_frame(input int line, input logic [7:0] d, input int np, input logic pbit,
                            input int ns, input logic [1:0] svals, input int glitch,
                            input logic rdp, input logic chk);
    logic [15:0] seq;
    logic [2:0]  v;
    logic        val, last;
    int          len;
    seq = '1;
    seq[0] = 1'b0;
    for (int i = 0; i < 8; i++) seq[1+i] = d[i];
    if (np != 0) seq[9] = pbit;
    for (int s = 0; s < ns; s++) seq[9+np+s] = svals[s];
    len = 9 + np + ns;
    for (int b = 0; b < len; b++) begin
      for (int i = 0; i < 16; i++) begin
        val = seq[b];
        if (b*16 + i == glitch) val = ~val;
        v = 3'b111;
        v[line] = val;
        last = (b == len-1) && (i == SMP);
        if (last && chk) begin
          checks++;
          if (rda_a !== 1'b0) begin fails++; $display("FAIL lat_pre rda=%0b exp=0", rda_a); end
        end
        tick(v, last & rdp);
        if (last && chk) begin
          checks++;
          if (rda_a !== 1'b1) begin fails++; $display("FAIL lat_post rda=%0b exp=1", rda_a); end
        end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; enable = 1'b0; rxd_a = 1'b1; rxd_b = 1'b1; rxd_c = 1'b1;
    rd_a = 1'b0; rd_b = 1'b0; rd_c = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (data_a !== 8'h00) begin fails++; $display("FAIL rst_data got=%h exp=00", data_a); end
    checks++; if (rda_a !== 1'b0) begin fails++; $display("FAIL rst_rda got=%0b exp=0", rda_a); end
    checks++; if (pe_a !== 1'b0) begin fails++; $display("FAIL rst_perr got=%0b exp=0", pe_a); end
    checks++; if (fe_a !== 1'b0) begin fails++; $display("FAIL rst_ferr got=%0b exp=0", fe_a); end
    checks++; if (ov_a !== 1'b0) begin fails++; $display("FAIL rst_ovr got=%0b exp=0", ov_a); end
    idle(4);
  endtask

  task automatic test_basic;
    send_frame(0, 8'hA5, 0, 1'b0, 1, 2'b11, -1, 1'b0, 1'b1);
    idle(2);
    checks++; if (data_a !== 8'hA5) begin fails++; $display("FAIL basic_data got=%h exp=a5", data_a); end
    checks++; if (pe_a !== 1'b0) begin fails++; $display("FAIL basic_perr got=%0b exp=0", pe_a); end
    checks++; if (fe_a !== 1'b0) begin fails++; $display("FAIL basic_ferr got=%0b exp=0", fe_a); end
    pop(0);
    checks++; if (rda_a !== 1'b0) begin fails++; $display("FAIL basic_empty rda=%0b exp=0", rda_a); end
    checks++; if (data_a !== 8'h00) begin fails++; $display("FAIL empty_data got=%h exp=00", data_a); end
  endtask

  task automatic test_parity;
    send_frame(1, 8'h03, 1, 1'b1, 1, 2'b11, -1, 1'b0, 1'b0);
    idle(2);
    checks++; if (data_b !== 8'h03) begin fails++; $display("FAIL par_data got=%h exp=03", data_b); end
    checks++; if (pe_b !== 1'b1) begin fails++; $display("FAIL par_err got=%0b exp=1", pe_b); end
    checks++; if (fe_b !== 1'b0) begin fails++; $display("FAIL par_ferr got=%0b exp=0", fe_b); end
    pop(1);
    send_frame(1, 8'h07, 1, 1'b1, 1, 2'b11, -1, 1'b0, 1'b0);
    idle(2);
    checks++; if (pe_b !== 1'b0 || data_b !== 8'h07) begin
      fails++; $display("FAIL par_ok got=%h/%0b exp=07/0", data_b, pe_b); end
    pop(1);
  endtask

  task automatic test_stop2;
    send_frame(2, 8'h5A, 0, 1'b0, 2, 2'b01, -1, 1'b0, 1'b0);
    idle(2);
    checks++; if (data_c !== 8'h5A) begin fails++; $display("FAIL stop2_data got=%h exp=5a", data_c); end
    checks++; if (fe_c !== 1'b1) begin fails++; $display("FAIL stop2_ferr got=%0b exp=1", fe_c); end
    checks++; if (pe_c !== 1'b0) begin fails++; $display("FAIL stop2_perr got=%0b exp=0", pe_c); end
    pop(2);
  endtask

  task automatic test_overrun;
    for (int f = 1; f <= 5; f++) begin
      send_frame(0, 8'(f), 0, 1'b0, 1, 2'b11, -1, 1'b0, 1'b0);
      idle(1);
      if (f == 4) begin
        checks++; if (ov_a !== 1'b0) begin fails++; $display("FAIL ovr_pre got=%0b exp=0", ov_a); end
      end
    end
    checks++; if (ov_a !== 1'b1) begin fails++; $display("FAIL ovr_set got=%0b exp=1", ov_a); end
    for (int k = 1; k <= 4; k++) begin
      checks++; if (data_a !== 8'(k)) begin fails++; $display("FAIL ovr_pop%0d got=%h exp=%h", k, data_a, 8'(k)); end
      pop(0);
    end
    checks++; if (rda_a !== 1'b0) begin fails++; $display("FAIL ovr_empty rda=%0b exp=0", rda_a); end
    checks++; if (ov_a !== 1'b0) begin fails++; $display("FAIL ovr_clr got=%0b exp=0", ov_a); end
  endtask

  task automatic test_back_to_back;
    for (int f = 0; f < 4; f++) begin
      send_frame(0, 8'h11 + 8'(f), 0, 1'b0, 1, 2'b11, -1, 1'b0, 1'b0);
      idle(1);
    end
    send_frame(0, 8'h15, 0, 1'b0, 1, 2'b11, -1, 1'b1, 1'b0);
    idle(1);
    checks++; if (ov_a !== 1'b0) begin fails++; $display("FAIL full_rd_ovr got=%0b exp=0", ov_a); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (data_a !== 8'h12 + 8'(k)) begin
        fails++; $display("FAIL full_rd_pop%0d got=%h exp=%h", k, data_a, 8'h12 + 8'(k)); end
      pop(0);
    end
    checks++; if (rda_a !== 1'b0) begin fails++; $display("FAIL full_rd_empty rda=%0b exp=0", rda_a); end
    send_frame(0, 8'h66, 0, 1'b0, 1, 2'b11, -1, 1'b1, 1'b0);
    idle(1);
    checks++; if (rda_a !== 1'b1 || data_a !== 8'h66) begin
      fails++; $display("FAIL empty_rd_push got=%0b/%h exp=1/66", rda_a, data_a); end
    pop(0);
  endtask

  task automatic test_glitch_reset;
    tick(3'b110, 1'b0);
    idle(30);
    checks++; if (rda_a !== 1'b0) begin fails++; $display("FAIL idle_glitch rda=%0b exp=0", rda_a); end
    for (int k = 0; k < 40; k++) tick(3'b110, 1'b0);
    @(negedge clk); rxd_a = 1'b1; rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(4);
    send_frame(0, 8'h3C, 0, 1'b0, 1, 2'b11, -1, 1'b0, 1'b0);
    idle(2);
    checks++; if (rda_a !== 1'b1 || data_a !== 8'h3C) begin
      fails++; $display("FAIL rst_mid got=%0b/%h exp=1/3c", rda_a, data_a); end
    pop(0);
    checks++; if (rda_a !== 1'b0) begin fails++; $display("FAIL rst_mid_only rda=%0b exp=0", rda_a); end
  endtask

  task automatic test_majority;
    logic [7:0] exp;
`ifdef SPART_RX_MAJORITY_EN
    exp = 8'hFF;
`else
    exp = 8'hFE;
`endif
    send_frame(0, 8'hFF, 0, 1'b0, 1, 2'b11, 16 + GLT, 1'b0, 1'b0);
    idle(2);
    checks++; if (data_a !== exp) begin fails++; $display("FAIL glitch_bit0 got=%h exp=%h", data_a, exp); end
    pop(0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_stop2();
    test_overrun();
    test_back_to_back();
    test_glitch_reset();
    test_majority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
